// File: rtl/cvp14_pkg.sv
// cvp14_pkg: shared types and constants for the CVP14 memory bus.
// Used by the responder, its word array and bus checkers.
package cvp14_pkg;

  localparam int BUS_W     = 16;
  localparam int BURST_LEN = 16;
  localparam int BEAT_W    = $clog2(BURST_LEN);

  // Vector opcodes that generate 16-beat bursts.
  localparam logic [3:0] OP_VLD = 4'hC;
  localparam logic [3:0] OP_VST = 4'hD;

  typedef logic [BUS_W-1:0]  word_t;
  typedef logic [BEAT_W-1:0] beat_t;

  localparam beat_t BEAT_LAST = beat_t'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    RWAIT,
    RBEAT,
    WBEAT,
    DONE
  } state_t;

endpackage

// File: rtl/cvp14_mem_array.sv
// cvp14_mem_array: word array, synchronous write, combinational read.
// Preload by hierarchical access to the mem array below.
module cvp14_mem_array
  import cvp14_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  word_t                 wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output word_t                 rdata
);

  word_t mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cvp14_mem_responder.sv
// cvp14_mem_responder: CVP14 bus memory target with single/16-beat
// bursts and a programmable read latency.
module cvp14_mem_responder
  import cvp14_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int READ_LAT   = 2
) (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic [15:0] Addr,
  input  logic        RD,
  input  logic        WR,
  input  logic        Burst,
  input  logic [15:0] WrData,
  output logic [15:0] RdData,
  output logic        Ack,
  output logic        Busy,
  output logic        Err
);

  typedef logic [DEPTH_LOG2-1:0] addr_t;

  localparam logic [2:0] LAT_INIT = 3'(READ_LAT - 2);
  localparam addr_t      ONE      = addr_t'(1);

  state_t state, state_d;
  addr_t  addr_q, addr_d;
  beat_t  cnt_q, cnt_d;
  logic [2:0] lat_q, lat_d;
  logic   burst_q, burst_d;
  word_t  hold_q, hold_d;
  logic   wack_q, wack_d;
  logic   err_q, err_d;

  logic   we;
  addr_t  waddr;
  word_t  rword;
  addr_t  a_in;
  logic   rd_req, wr_req, bad_req;
  logic   unused_addr;

  assign a_in        = Addr[DEPTH_LOG2-1:0];
  assign unused_addr = ^(Addr >> DEPTH_LOG2);
  assign rd_req      = RD & ~WR;
  assign wr_req      = WR & ~RD;
  assign bad_req     = RD & WR;

  cvp14_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk   (Clk1),
    .we    (we & Reset),
    .waddr (waddr),
    .wdata (WrData),
    .raddr (addr_q),
    .rdata (rword)
  );

  always_comb begin
    state_d = state;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    burst_d = burst_q;
    hold_d  = hold_q;
    wack_d  = 1'b0;
    err_d   = 1'b0;
    we      = 1'b0;
    waddr   = addr_q;
    Ack     = wack_q;
    RdData  = hold_q;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          rd_req: begin
            addr_d  = a_in;
            burst_d = Burst;
            cnt_d   = '0;
            lat_d   = LAT_INIT;
            state_d = (READ_LAT == 1) ? RBEAT : RWAIT;
          end
          wr_req: begin
            // Beat 0 is written on the accepting edge itself.
            we      = 1'b1;
            waddr   = a_in;
            wack_d  = 1'b1;
            addr_d  = a_in + ONE;
            burst_d = Burst;
            cnt_d   = beat_t'(1);
            state_d = Burst ? WBEAT : DONE;
          end
          bad_req: err_d = 1'b1;
          default: ;
        endcase
      end
      RWAIT: begin
        if (lat_q == '0) state_d = RBEAT;
        else lat_d = lat_q - 3'd1;
      end
      RBEAT: begin
        Ack    = 1'b1;
        RdData = rword;
        hold_d = rword;
        addr_d = addr_q + ONE;
        cnt_d  = cnt_q + beat_t'(1);
        if (!burst_q || cnt_q == BEAT_LAST)
          state_d = DONE;
      end
      WBEAT: begin
        we     = 1'b1;
        wack_d = 1'b1;
        addr_d = addr_q + ONE;
        cnt_d  = cnt_q + beat_t'(1);
        if (cnt_q == BEAT_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk1) begin
    if (!Reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      burst_q <= 1'b0;
      hold_q  <= '0;
      wack_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      burst_q <= burst_d;
      hold_q  <= hold_d;
      wack_q  <= wack_d;
      err_q   <= err_d;
    end
  end

  assign Busy = (state != IDLE);
  assign Err  = err_q;

endmodule

// File: tb/tb_cvp14_mem_responder.sv
// tb_cvp14_mem_responder: cycle-scheduled model of the responder,
// directed + random traffic, plus a READ_LAT 1..7 latency sweep.
module tb_cvp14_mem_responder;

  localparam int LAT   = 2;
  localparam int NC    = 16384;
  localparam int DEPTH = 4096;

  logic Clk1 = 1'b0;
  always #5 Clk1 = ~Clk1;

  logic        Reset, RD, WR, Burst;
  logic [15:0] Addr, WrData, RdData;
  logic        Ack, Busy, Err;
  logic        sw_rst;

  cvp14_mem_responder #(
    .DEPTH_LOG2(12),
    .READ_LAT  (LAT)
  ) dut (
    .Clk1  (Clk1),
    .Reset (Reset),
    .Addr  (Addr),
    .RD    (RD),
    .WR    (WR),
    .Burst (Burst),
    .WrData(WrData),
    .RdData(RdData),
    .Ack   (Ack),
    .Busy  (Busy),
    .Err   (Err)
  );

  int cyc = 0;
  always @(posedge Clk1) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic        ack;
    logic        busy;
    logic        err;
    logic        rdset;
    logic        rst;
    logic [15:0] rdv;
  } exp_t;

  exp_t        ex [NC];
  logic [15:0] mm [DEPTH];
  logic        obs_ack [NC];
  logic        obs_busy[NC];
  logic        obs_err [NC];
  logic [15:0] obs_rd  [NC];
  logic [15:0] model_rd = 16'h0;
  logic        chk_en = 1'b0;
  exp_t        cur;

  // Compare DUT outputs to the schedule every cycle.
  always @(negedge Clk1) begin
    if (chk_en && cyc < NC) begin
      cur = ex[cyc];
      if (cur.rst)   model_rd = 16'h0;
      if (cur.rdset) model_rd = cur.rdv;
      chk("ack",    32'(Ack),    32'(cur.ack));
      chk("busy",   32'(Busy),   32'(cur.busy));
      chk("err",    32'(Err),    32'(cur.err));
      chk("rddata", 32'(RdData), 32'(model_rd));
      obs_ack[cyc]  = Ack;
      obs_busy[cyc] = Busy;
      obs_err[cyc]  = Err;
      obs_rd[cyc]   = RdData;
    end
  end

  function automatic int wa(input logic [15:0] a, input int i);
    return (int'(a[11:0]) + i) % DEPTH;
  endfunction

  task automatic set_busy(input int from, input int to);
    for (int k = from; k <= to; k++) ex[k].busy = 1'b1;
  endtask

  task automatic do_read(input logic [15:0] a, input logic b,
                         input logic hold, output int c);
    int n;
    c = cyc;
    n = b ? 16 : 1;
    RD = 1'b1; WR = 1'b0; Addr = a; Burst = b;
    for (int i = 0; i < n; i++) begin
      ex[c+LAT+i].ack   = 1'b1;
      ex[c+LAT+i].rdset = 1'b1;
      ex[c+LAT+i].rdv   = mm[wa(a, i)];
    end
    set_busy(c + 1, c + LAT + n);
    for (int k = 1; k <= LAT + n + 1; k++) begin
      @(negedge Clk1);
      Addr  = 16'($urandom);
      Burst = 1'($urandom);
    end
    if (!hold) RD = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic b,
                          input logic [15:0] d0, input logic rnd,
                          output int c);
    int n;
    logic [15:0] d[16];
    c = cyc;
    n = b ? 16 : 1;
    for (int i = 0; i < 16; i++)
      d[i] = rnd ? 16'($urandom) : d0 + 16'(i);
    for (int i = 0; i < n; i++) begin
      mm[wa(a, i)]    = d[i];
      ex[c+1+i].ack   = 1'b1;
    end
    set_busy(c + 1, c + n);
    WR = 1'b1; RD = 1'b0; Addr = a; Burst = b; WrData = d[0];
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge Clk1);
      WR    = 1'b0;
      Addr  = 16'($urandom);
      Burst = 1'($urandom);
      WrData = (k < n) ? d[k] : 16'($urandom);
    end
  endtask

  task automatic do_err(input logic [15:0] a, output int c);
    c = cyc;
    RD = 1'b1; WR = 1'b1; Addr = a;
    Burst = 1'($urandom); WrData = 16'($urandom);
    ex[c+1].err = 1'b1;
    @(negedge Clk1);
    RD = 1'b0; WR = 1'b0;
  endtask

  task automatic do_rst_burst(input logic [15:0] a, output int c);
    c = cyc;
    RD = 1'b1; WR = 1'b0; Addr = a; Burst = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      ex[c+LAT+i].ack   = 1'b1;
      ex[c+LAT+i].rdset = 1'b1;
      ex[c+LAT+i].rdv   = mm[wa(a, i)];
    end
    set_busy(c + 1, c + LAT + 5);
    repeat (LAT + 5) @(negedge Clk1);
    RD = 1'b0; Reset = 1'b0;
    ex[c+LAT+6].rst = 1'b1;
    @(negedge Clk1);
    Reset = 1'b1;
  endtask

  task automatic do_rst_write(input logic [15:0] a,
                              input logic [15:0] d, output int c);
    c = cyc;
    WR = 1'b1; RD = 1'b0; Addr = a; Burst = 1'b0; WrData = d;
    Reset = 1'b0;
    ex[c+1].rst = 1'b1;
    @(negedge Clk1);
    WR = 1'b0; Reset = 1'b1;
  endtask

  // Latency sweep: one responder per READ_LAT value.
  for (genvar g = 1; g <= 7; g++) begin : sw
    logic        rd, wr, bu, ack, busy, err, done;
    logic [15:0] ad, wd, rdd;

    cvp14_mem_responder #(
      .DEPTH_LOG2(12),
      .READ_LAT  (g)
    ) u (
      .Clk1  (Clk1),
      .Reset (sw_rst),
      .Addr  (ad),
      .RD    (rd),
      .WR    (wr),
      .Burst (bu),
      .WrData(wd),
      .RdData(rdd),
      .Ack   (ack),
      .Busy  (busy),
      .Err   (err)
    );

    initial begin
      int lat, nack, bad;
      done = 1'b0; rd = 1'b0; wr = 1'b0; bu = 1'b0;
      ad = 16'h0; wd = 16'h0;
      wait (sw_rst === 1'b1);
      @(negedge Clk1);
      wr = 1'b1; bu = 1'b1; ad = 16'h0FFA; wd = 16'(g * 256);
      for (int i = 1; i <= 16; i++) begin
        @(negedge Clk1);
        wr = 1'b0;
        wd = 16'(g * 256 + i);
      end
      @(negedge Clk1);
      for (int m = 0; m < 2; m++) begin
        rd = 1'b1; bu = m[0]; ad = 16'h0FFA;
        lat = 0; nack = 0; bad = 0;
        while (lat < 20 && ack !== 1'b1) begin
          @(negedge Clk1);
          lat++;
        end
        rd = 1'b0;
        chk($sformatf("sw%0d_lat_m%0d", g, m), 32'(lat), 32'(g));
        while (ack === 1'b1 && nack < 20) begin
          if (rdd !== 16'(g * 256 + nack)) bad++;
          nack++;
          @(negedge Clk1);
        end
        chk($sformatf("sw%0d_beats_m%0d", g, m),
            32'(nack), m ? 32'd16 : 32'd1);
        chk($sformatf("sw%0d_data_m%0d", g, m), 32'(bad), 32'd0);
        for (int k = 0; k < 10 && busy === 1'b1; k++)
          @(negedge Clk1);
        chk($sformatf("sw%0d_idle_m%0d", g, m), 32'(busy), 32'd0);
      end
      chk($sformatf("sw%0d_err", g), 32'(err), 32'd0);
      done = 1'b1;
    end
  end

  initial begin
    int c, c2, n, op, off, alldone;
    logic [31:0] r;
    logic [15:0] a;
    Reset = 1'b0; RD = 1'b0; WR = 1'b0; Burst = 1'b0;
    Addr = 16'h0; WrData = 16'h0; sw_rst = 1'b0;
    for (int i = 0; i < NC; i++) ex[i] = '0;
    @(negedge Clk1);
    chk_en = 1'b1;
    @(negedge Clk1);
    chk("rst_ack",  32'(Ack),    32'd0);
    chk("rst_busy", 32'(Busy),   32'd0);
    chk("rst_err",  32'(Err),    32'd0);
    chk("rst_rd",   32'(RdData), 32'd0);
    Reset = 1'b1; sw_rst = 1'b1;

    // Preload the window 0xF00..0x0FF (wraps through 0).
    for (int p = 0; p < 32; p++)
      do_write(16'((12'hF00 + 12'(16 * p))), 1'b1, 16'h0, 1'b1, c);

    do_write(16'h0010, 1'b0, 16'hBEEF, 1'b0, c);
    chk("wr_ack_t1",  32'(obs_ack[c+1]),  32'd1);
    chk("wr_idle_t2", 32'(obs_busy[c+2]), 32'd0);
    do_read(16'h0010, 1'b0, 1'b0, c);
    chk("rd_noack_t1", 32'(obs_ack[c+1]), 32'd0);
    chk("rd_ack_t2",   32'(obs_ack[c+2]), 32'd1);
    chk("rd_beef",     32'(obs_rd[c+2]),  32'hBEEF);
    chk("rd_done_t3",  32'(obs_ack[c+3]), 32'd0);

    do_write(16'h0FF8, 1'b1, 16'h1000, 1'b0, c);
    chk("bw_ack_t16",  32'(obs_ack[c+16]),  32'd1);
    chk("bw_idle_t17", 32'(obs_busy[c+17]), 32'd0);
    do_read(16'h0FF8, 1'b1, 1'b0, c);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("br_ack%0d", i), 32'(obs_ack[c+2+i]), 32'd1);
      chk($sformatf("br_dat%0d", i), 32'(obs_rd[c+2+i]),
          32'h1000 + 32'(i));
    end
    chk("br_end", 32'(obs_ack[c+18]), 32'd0);
    do_read(16'hA000, 1'b0, 1'b0, c);
    chk("wrap_alias", 32'(obs_rd[c+2]), 32'h1008);

    do_err(16'h0010, c);
    do_read(16'h0010, 1'b0, 1'b0, c2);
    chk("err_pulse",  32'(obs_err[c+1]), 32'd1);
    chk("err_once",   32'(obs_err[c+2]), 32'd0);
    chk("err_noack",  32'(obs_ack[c+1]), 32'd0);
    chk("err_nowr",   32'(obs_rd[c2+2]), 32'hBEEF);

    do_read(16'h0FF9, 1'b0, 1'b1, c);
    do_read(16'h0FFA, 1'b0, 1'b0, c2);
    chk("held_start", 32'(c2 - c), 32'd4);
    chk("held_done",  32'(obs_ack[c+3]), 32'd0);
    chk("held_rd1",   32'(obs_rd[c+2]),  32'h1001);
    chk("held_rd2",   32'(obs_rd[c2+2]), 32'h1002);

    do_rst_burst(16'h0FF8, c);
    @(negedge Clk1);
    chk("mid_beat5", 32'(obs_rd[c+7]),   32'h1005);
    chk("mid_ack",   32'(obs_ack[c+8]),  32'd0);
    chk("mid_busy",  32'(obs_busy[c+8]), 32'd0);
    chk("mid_rd",    32'(obs_rd[c+8]),   32'd0);
    do_read(16'h0010, 1'b0, 1'b0, c);
    chk("mid_after", 32'(obs_rd[c+2]), 32'hBEEF);

    do_rst_write(16'h0010, 16'h1234, c);
    do_read(16'h0010, 1'b0, 1'b0, c);
    chk("rst_nowr", 32'(obs_rd[c+2]), 32'hBEEF);

    for (int it = 0; it < 150; it++) begin
      r   = $urandom;
      off = $urandom_range(0, 496);
      a   = {r[15:12], 12'(12'hF00 + 12'(off))};
      op  = $urandom_range(0, 9);
      if (op <= 3) do_read(a, r[0], 1'b0, c);
      else if (op <= 7) do_write(a, r[1], 16'h0, 1'b1, c);
      else if (op == 8) do_err(a, c);
      else begin
        do_read(a, 1'b0, 1'b1, c);
        do_read(a, r[0], 1'b0, c);
      end
      n = $urandom_range(0, 2);
      repeat (n) @(negedge Clk1);
    end

    alldone = 0;
    for (int k = 0; k < 3000 && alldone == 0; k++) begin
      alldone = (sw[1].done && sw[2].done && sw[3].done &&
                 sw[4].done && sw[5].done && sw[6].done &&
                 sw[7].done) ? 1 : 0;
      if (alldone == 0) @(negedge Clk1);
    end
    chk("sweep_finished", 32'(alldone), 32'd1);
    repeat (2) @(negedge Clk1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
